// File: rtl/yapp_router_pkg.sv
// Shared types and constants for the YAPP router input side.
package yapp_router_pkg;

  localparam int YAPP_DATA_W  = 8;
  localparam int YAPP_MAX_LEN = 63;

  // Header byte layout: {length[7:2], addr[1:0]}
  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } yapp_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    PARITY,
    DROP
  } ctrl_state_e;

endpackage

// File: rtl/yapp_parity_acc.sv
// Byte-wide XOR accumulator for YAPP even parity.
// mismatch compares the running value against the presented byte, so it is
// valid combinationally while the parity byte sits on din.
module yapp_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              xor_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc,
  output logic              mismatch
);

  // Accumulator: clear wins over load, load wins over xor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       acc <= '0;
    else if (clear)  acc <= '0;
    else if (load)   acc <= din;
    else if (xor_en) acc <= acc ^ din;
  end

  assign mismatch = (acc ^ din) != '0;

endmodule

// File: rtl/yapp_pkt_ctrl.sv
// YAPP input packet controller: parses header/payload/parity, steers legal
// packets into the addressed output FIFO, drops illegal-address packets and
// back-pressures the source when the target FIFO is full.
// Optional build macro YAPP_PKT_STATS_EN adds saturating packet counters.
module yapp_pkt_ctrl
  import yapp_router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = YAPP_DATA_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 in_data_vld,
  output logic                 suspend_data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic [DATA_W-1:0]    fifo_data,
  output logic                 err,
  output logic                 addr_err,
  output logic                 pkt_active
`ifdef YAPP_PKT_STATS_EN
  ,
  output logic [15:0]          good_pkt_cnt,
  output logic [15:0]          bad_par_cnt,
  output logic [15:0]          drop_cnt
`endif
);

  ctrl_state_e state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [1:0]  cur_addr, cur_addr_nxt;
  yapp_hdr_t   hdr;
  logic        accept;
  logic [3:0]  full_pad;
  logic        wr_p0, err_p0, addr_err_p0;
  logic        acc_clear, acc_load, acc_xor;
  logic [DATA_W-1:0] acc_val;
  logic        mismatch;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [1:0] a);
    onehot = NUM_PORTS'(1) << a;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hdr        = yapp_hdr_t'(data_in[7:0]);
  assign accept     = in_data_vld && !suspend_data_in;
  assign pkt_active = (state != IDLE);

  // Widen the full flags to the 2-bit address space so any addr indexes safely.
  always_comb begin
    full_pad = '0;
    full_pad[NUM_PORTS-1:0] = fifo_full;
  end

  assign suspend_data_in = ((state == PAYLOAD) || (state == PARITY)) && full_pad[cur_addr];

  yapp_parity_acc #(.DATA_W(DATA_W)) u_parity_acc (
    .clock    (clock),
    .reset    (reset),
    .clear    (acc_clear),
    .load     (acc_load),
    .xor_en   (acc_xor),
    .din      (data_in),
    .acc      (acc_val),
    .mismatch (mismatch)
  );

  // Next-state and per-byte decisions for the accepted byte.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_addr_nxt = cur_addr;
    wr_p0        = 1'b0;
    err_p0       = 1'b0;
    addr_err_p0  = 1'b0;
    acc_clear    = 1'b0;
    acc_load     = 1'b0;
    acc_xor      = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          cur_addr_nxt = hdr.addr;
          cnt_nxt      = hdr.len;
          acc_load     = 1'b1;
          if (32'(hdr.addr) >= NUM_PORTS) begin
            addr_err_p0 = 1'b1;
            state_nxt   = DROP;
          end else begin
            wr_p0     = 1'b1;
            state_nxt = (hdr.len != 6'd0) ? PAYLOAD : PARITY;
          end
        end
        PAYLOAD: begin
          wr_p0   = 1'b1;
          acc_xor = 1'b1;
          cnt_nxt = cnt - 6'd1;
          if (cnt == 6'd1) state_nxt = PARITY;
        end
        PARITY: begin
          wr_p0     = 1'b1;
          err_p0    = mismatch;
          acc_clear = 1'b1;
          state_nxt = IDLE;
        end
        DROP: begin
          // cnt counts payload bytes left; the byte seen at cnt==0 is parity.
          if (cnt == 6'd0) begin
            acc_clear = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 6'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_addr <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_addr <= cur_addr_nxt;
    end
  end

  // Registered FIFO write port and error pulses (stage p0 -> outputs).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_enb <= '0;
      fifo_data <= '0;
      err       <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      write_enb <= wr_p0 ? onehot(cur_addr_nxt) : '0;
      if (wr_p0) fifo_data <= data_in;
      err       <= err_p0;
      addr_err  <= addr_err_p0;
    end
  end

`ifdef YAPP_PKT_STATS_EN
  logic par_done, drop_done;
  assign par_done  = accept && (state == PARITY);
  assign drop_done = accept && (state == DROP) && (cnt == 6'd0);

  // Saturating packet statistics, updated alongside the err pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      good_pkt_cnt <= '0;
      bad_par_cnt  <= '0;
      drop_cnt     <= '0;
    end else begin
      if (par_done && !mismatch) good_pkt_cnt <= sat_inc16(good_pkt_cnt);
      if (par_done && mismatch)  bad_par_cnt  <= sat_inc16(bad_par_cnt);
      if (drop_done)             drop_cnt     <= sat_inc16(drop_cnt);
    end
  end
`endif

endmodule
